// File: rtl/mem_arb.sv
// mem_arb: round-robin arbiter giving two requesters single-access use of one memory port, with a wait timeout.
module mem_arb #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          done0,
  output logic          done1,
  output logic          err0,
  output logic          err1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  logic [1:0]    r_state;
  logic          r_owner;
  logic          r_last;
  logic          r_we;
  logic          r_err;
  logic [7:0]    r_cnt;
  logic [AW-1:0] r_adr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;
  logic          w_grant;
  logic          w_acc;
  logic          w_done;
  logic          w_fin;
  logic [DW-1:0] w_val;
  assign w_grant = (req0 & req1) ? ~r_last : req1;
  assign w_acc   = r_state == S_ACC;
  assign w_done  = r_state == S_DONE;
  assign w_fin   = mem_ready | (r_cnt == 8'(TIMEOUT - 1));
  assign w_val   = mem_ready ? mem_rdata : '0;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_adr    <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (req0 | req1) begin
          r_state <= S_ACC;
          r_owner <= w_grant;
          r_last  <= w_grant;
          r_we    <= w_grant ? we1 : we0;
          r_adr   <= w_grant ? addr1 : addr0;
          r_wdata <= w_grant ? wdata1 : wdata0;
          r_cnt   <= '0;
          r_err   <= 1'b0;
        end
        S_ACC: begin
          r_cnt <= r_cnt + 8'd1;
          // a timed-out read returns zero; writes never touch read data
          if (w_fin) begin
            r_state <= S_DONE;
            r_err   <= ~mem_ready;
            if (!r_we && !r_owner) r_rdata0 <= w_val;
            if (!r_we && r_owner) r_rdata1 <= w_val;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign mem_req   = w_acc;
  assign mem_we    = w_acc & r_we;
  assign mem_adr   = r_adr;
  assign mem_wdata = r_wdata;
  assign done0     = w_done & ~r_owner;
  assign done1     = w_done & r_owner;
  assign err0      = done0 & r_err;
  assign err1      = done1 & r_err;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign busy      = r_state != S_IDLE;
endmodule
